if_fetch_unit: RTL
==================

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter BHT_ENTRIES, default 16, meaning the number of 2-bit predictor counters (power of two, 4..64).
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 inst_mem_read_data  input  32  instruction at inst_mem_read_addr, same-cycle combinational from instruction memory.
REQ-006 EX_stall  input  1  front-end hold request.
REQ-007 ID_branch  input  1  unconditional jump decoded in ID.
REQ-008 ID_jump_target  input  32  jump target, valid with ID_branch.
REQ-009 EX_branch  input  1  conditional branch resolved in EX this cycle; asserted exactly one cycle per branch.
REQ-010 EX_zero  input  1  actual branch outcome, 1 = taken.
REQ-011 EX_pred_take  input  1  IF_take value carried down the pipeline with that branch.
REQ-012 EX_pc  input  32  address of the resolving branch.
REQ-013 EX_target  input  32  computed taken target of the resolving branch.
REQ-014 inst_mem_read_addr  output  32  current PC (registered).
REQ-015 IF_take  output  1  prediction for the instruction currently fetched.
REQ-016 branch_count  output  32  number of resolved conditional branches.
REQ-017 mispredict_count  output  32  number of mispredicted branches.

Function
REQ-018 A fetched instruction SHALL be a conditional branch when inst_mem_read_data[6:0] == 7'b1100011.
REQ-019 IF_take SHALL be combinational: (fetched instruction is a branch) AND (bit[1] of counter[PC[log2(BHT_ENTRIES)+1:2]]).
REQ-020 Predicted target SHALL be PC + sign-extended B-immediate {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}, computed modulo 2^32.
REQ-021 mispredict SHALL be defined as EX_branch AND (EX_zero != EX_pred_take).
REQ-022 Next-PC priority SHALL be, highest first:
  - mispredict -> EX_target if EX_zero, else EX_pc+4;
  - EX_stall -> hold PC;
  - ID_branch -> ID_jump_target;
  - IF_take -> predicted target;
  - otherwise PC+4.
REQ-023 All PC arithmetic SHALL wrap modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
REQ-024 On EX_branch, counter[EX_pc index] SHALL update the next edge: increment saturating at 2'b11 if EX_zero, decrement saturating at 2'b00 otherwise.
REQ-025 Counter updates SHALL occur regardless of EX_stall.
REQ-026 When a read and an update hit the same index in one cycle, the read SHALL return the old value (no bypass).
REQ-027 branch_count SHALL increment on every EX_branch.
REQ-028 mispredict_count SHALL increment on every mispredict.
REQ-029 Both counters SHALL wrap at 2^32.
REQ-030 The PC SHALL be updated on every edge with no added latency: redirect takes effect at the next fetch address.

Reset
REQ-031 On reset, PC SHALL be RESET_PC.
REQ-032 On reset, all counters SHALL be 2'b01 (weakly not-taken).
REQ-033 On reset, branch_count and mispredict_count SHALL be 0.
REQ-034 IF_take SHALL follow from the reset state, which makes it 0.
REQ-035 Reset asserted mid-operation SHALL override all events, including a same-cycle mispredict, and SHALL take effect asynchronously.

Structure
REQ-036 A shared package SHALL hold: OPC_BRANCH = 7'b1100011; counter encodings SNT=00, WNT=01, WT=10, ST=11; and the B-immediate extraction function.
REQ-037 The counter table SHALL be a sub-module if_bht providing one combinational read port and one synchronous update port, with reset to WNT.

Verification
REQ-038 Reset release, NOP stream (0x00000013), no events -> addresses 0, 4, 8, 12; IF_take = 0 throughout.
REQ-039 Branch 0x00000863 (beq, +16) at PC 8 after two taken resolutions for EX_pc 8 (counter reaches 11) -> IF_take = 1 and next address 24.
REQ-040 EX_branch = 1, EX_zero = 0, EX_pred_take = 1, EX_pc = 0x40, with EX_stall = 1 and ID_branch = 1 -> next address 0x44; mispredict_count +1; counter[0x40 index] decremented.
REQ-041 EX_stall = 1 for 3 cycles at PC 0x20 -> address stays 0x20; ID_branch with target 0x100 then lands only after stall drops.
REQ-042 PC = 0xFFFF_FFFC, NOP -> next address 0x0000_0000.
REQ-043 Counter at 11 receives taken update -> stays 11; counter at 00 receives not-taken update -> stays 00; read-and-update in the same cycle returns the old value.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
// rtl/if_fetch_unit_pkg.sv - shared encodings and helpers for the fetch unit
package if_fetch_unit_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_ctr_e;

    function automatic logic [31:0] b_imm(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/if_fetch_unit_bht.sv
// rtl/if_fetch_unit_bht.sv - 2-bit saturating branch history table
module if_bht
    import if_fetch_unit_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_ctr,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    bht_ctr_e ctr_q [ENTRIES];
    bht_ctr_e ctr_d [ENTRIES];

    // Read comes straight from the registered table, so a same-cycle update is not visible
    assign rd_ctr = ctr_q[rd_idx];

    always_comb begin
        ctr_d = ctr_q;
        if (upd_en) begin
            unique case (ctr_q[upd_idx])
                SNT: ctr_d[upd_idx] = upd_taken ? WNT : SNT;
                WNT: ctr_d[upd_idx] = upd_taken ? WT  : SNT;
                WT:  ctr_d[upd_idx] = upd_taken ? ST  : WNT;
                ST:  ctr_d[upd_idx] = upd_taken ? ST  : WT;
                default: ctr_d[upd_idx] = WNT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= WNT;
            end
        end else begin
            ctr_q <= ctr_d;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - PC generation with bimodal branch prediction
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BHT_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] inst_mem_read_data,
    input  logic        EX_stall,
    input  logic        ID_branch,
    input  logic [31:0] ID_jump_target,
    input  logic        EX_branch,
    input  logic        EX_zero,
    input  logic        EX_pred_take,
    input  logic [31:0] EX_pc,
    input  logic [31:0] EX_target,
    output logic [31:0] inst_mem_read_addr,
    output logic        IF_take,
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [31:0] pc_q, pc_d;
    logic [31:0] branch_count_q, branch_count_d;
    logic [31:0] mispredict_count_q, mispredict_count_d;
    logic [1:0]  rd_ctr;
    logic        is_branch;
    logic        mispredict;
    logic [31:0] pred_target;

    if_bht #(
        .ENTRIES (BHT_ENTRIES),
        .IDX_W   (IDX_W)
    ) u_bht (
        .clk       (clk),
        .reset     (reset),
        .rd_idx    (pc_q[IDX_W+1:2]),
        .rd_ctr    (rd_ctr),
        .upd_en    (EX_branch),
        .upd_idx   (EX_pc[IDX_W+1:2]),
        .upd_taken (EX_zero)
    );

    assign is_branch   = (inst_mem_read_data[6:0] == OPC_BRANCH);
    assign IF_take     = is_branch & rd_ctr[1];
    assign pred_target = pc_q + b_imm(inst_mem_read_data);
    assign mispredict  = EX_branch & (EX_zero != EX_pred_take);

    // Recovery from a wrong prediction must win even over a stall
    always_comb begin
        pc_d = pc_q + 32'd4;
        if (mispredict) begin
            pc_d = EX_zero ? EX_target : (EX_pc + 32'd4);
        end else if (EX_stall) begin
            pc_d = pc_q;
        end else if (ID_branch) begin
            pc_d = ID_jump_target;
        end else if (IF_take) begin
            pc_d = pred_target;
        end
    end

    always_comb begin
        branch_count_d     = branch_count_q + {31'd0, EX_branch};
        mispredict_count_d = mispredict_count_q + {31'd0, mispredict};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q               <= RESET_PC;
            branch_count_q     <= 32'd0;
            mispredict_count_q <= 32'd0;
        end else begin
            pc_q               <= pc_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign inst_mem_read_addr = pc_q;
    assign branch_count       = branch_count_q;
    assign mispredict_count   = mispredict_count_q;

endmodule
